// File: rtl/fir_pkg.sv
// Shared defaults, FSM state encoding and sequencing lengths for the
// multi-channel time-multiplexed FIR scheduler.
package fir_pkg;

  localparam int FIR_WIDTH = 24;
  localparam int FIR_TAPS  = 128;
  localparam int FIR_NCH   = 4;
  localparam int FIR_SHIFT = 18;

  // Cycles spent after the last MAC address: one for read latency, one for the multiplier register.
  localparam int DRAIN_LEN = 2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_MAC,
    ST_DRAIN,
    ST_OUT
  } state_e;

  // INIT clears the whole delay RAM, one word per cycle.
  function automatic int init_len(input int nch, input int taps);
    return nch * taps;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate with a registered product; the accumulator
// wraps modulo 2^(2*WIDTH). clr empties both the pipeline and the sum.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int WIDTH = FIR_WIDTH
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      en,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] acc
);

  logic signed [2*WIDTH-1:0] prod_p1_d;
  logic signed [2*WIDTH-1:0] prod_p1_q;
  logic                      vld_p1_q;
  logic signed [2*WIDTH-1:0] acc_p2_d;
  logic signed [2*WIDTH-1:0] acc_p2_q;

  always_comb begin
    prod_p1_d = a * b;
    acc_p2_d  = acc_p2_q;
    if (clr) begin
      acc_p2_d = '0;
    end else if (vld_p1_q) begin
      acc_p2_d = acc_p2_q + prod_p1_q;
    end
  end

  // p0 -> p1: product register
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= en;
    end
    prod_p1_q <= prod_p1_d;
  end

  // p1 -> p2: accumulator
  always_ff @(posedge clk) begin
    acc_p2_q <= acc_p2_d;
  end

  assign acc = acc_p2_q;

endmodule

// File: rtl/fir_chan_sched.sv
// Round-robin scheduler that time-shares one MAC across NCH FIR channels,
// each with its own circular delay line in an external RAM.
module fir_chan_sched
  import fir_pkg::*;
#(
  parameter int WIDTH = FIR_WIDTH,
  parameter int TAPS  = FIR_TAPS,
  parameter int NCH   = FIR_NCH,
  parameter int SHIFT = FIR_SHIFT,
  localparam int TW   = $clog2(TAPS),
  localparam int CW   = $clog2(NCH),
  localparam int AW   = $clog2(NCH * TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req,
  input  logic [NCH*WIDTH-1:0]    sample,
  output logic [NCH-1:0]          ack,
  output logic                    busy,
  output logic [TW-1:0]           coef_addr,
  input  logic signed [WIDTH-1:0] coef_data,
  output logic [AW-1:0]           del_addr,
  output logic                    del_we,
  output logic signed [WIDTH-1:0] del_wdata,
  input  logic signed [WIDTH-1:0] del_rdata,
  output logic                    out_valid,
  output logic [CW-1:0]           out_ch,
  output logic signed [WIDTH-1:0] out_data
);

  localparam int INIT_LEN = init_len(NCH, TAPS);

  state_e                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic [CW-1:0]           rr_q, rr_d;
  logic signed [WIDTH-1:0] samp_q, samp_d;
  logic [TW-1:0]           wptr_q [NCH];
  logic [TW-1:0]           wptr_d [NCH];
  logic                    rd_vld_q, rd_vld_d;

  logic                    grant_vld;
  logic [CW-1:0]           grant_ch;
  logic [CW-1:0]           idx;
  logic                    mac_clr;
  logic signed [2*WIDTH-1:0] acc;

  function automatic logic signed [WIDTH-1:0] trunc_acc(input logic signed [2*WIDTH-1:0] a);
    return a[SHIFT+WIDTH-1:SHIFT];
  endfunction

  // Scan starts just after the last granted channel, so it naturally wraps.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = rr_q + CW'(i);
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    rr_d      = rr_q;
    samp_d    = samp_q;
    wptr_d    = wptr_q;
    rd_vld_d  = (state_q == ST_MAC);
    ack       = '0;
    busy      = 1'b1;
    coef_addr = '0;
    del_addr  = '0;
    del_we    = 1'b0;
    del_wdata = '0;
    out_valid = 1'b0;
    out_ch    = '0;
    out_data  = '0;
    mac_clr   = 1'b0;
    case (state_q)
      ST_INIT: begin
        del_we   = 1'b1;
        del_addr = cnt_q;
        if (cnt_q == AW'(INIT_LEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (grant_vld) begin
          ack[grant_ch] = 1'b1;
          ch_d          = grant_ch;
          rr_d          = grant_ch;
          samp_d        = sample[int'(grant_ch)*WIDTH +: WIDTH];
          state_d       = ST_WRITE;
        end
      end
      ST_WRITE: begin
        del_we    = 1'b1;
        del_addr  = {ch_q, wptr_q[ch_q]};
        del_wdata = samp_q;
        mac_clr   = 1'b1;
        cnt_d     = '0;
        state_d   = ST_MAC;
      end
      ST_MAC: begin
        // Newest sample pairs with coefficient 0, walking back through history.
        coef_addr = cnt_q[TW-1:0];
        del_addr  = {ch_q, wptr_q[ch_q] - cnt_q[TW-1:0]};
        if (cnt_q == AW'(TAPS - 1)) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == AW'(DRAIN_LEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OUT: begin
        out_valid    = 1'b1;
        out_ch       = ch_q;
        out_data     = trunc_acc(acc);
        wptr_d[ch_q] = wptr_q[ch_q] + 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // p0: control state and captured sample
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      rr_q     <= CW'(NCH - 1);
      rd_vld_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        wptr_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      rd_vld_q <= rd_vld_d;
      wptr_q   <= wptr_d;
    end
    ch_q   <= ch_d;
    samp_q <= samp_d;
  end

  fir_mac_unit #(
    .WIDTH (WIDTH)
  ) u_mac (
    .clk (clk),
    .clr (mac_clr | rst),
    .en  (rd_vld_q),
    .a   (coef_data),
    .b   (del_rdata),
    .acc (acc)
  );

endmodule
